// File: rtl/instr_obi_arbiter.sv
// instr_obi_arbiter
//   Shares one instruction-memory OBI read port between two requesters (m0: core fetch,
//   m1: secondary read-only fetch). Round-robin arbitration with a hold lock keeps a
//   presented request stable until granted. An in-order ID FIFO routes each response back
//   to the requester that issued it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   m0_*/m1_*             requester side: req/addr in; gnt/rvalid/rdata/err out
//   s_*                   shared port: req/addr out; gnt/rvalid/rdata/err in
//   outstanding           current ID FIFO occupancy
//   protocol_err          sticky flag, set when a response arrives with nothing outstanding
module instr_obi_arbiter #(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned DW             = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  m0_req,
    input  logic [31:0]                           m0_addr,
    output logic                                  m0_gnt,
    output logic                                  m0_rvalid,
    output logic [DW-1:0]                         m0_rdata,
    output logic                                  m0_err,
    input  logic                                  m1_req,
    input  logic [31:0]                           m1_addr,
    output logic                                  m1_gnt,
    output logic                                  m1_rvalid,
    output logic [DW-1:0]                         m1_rdata,
    output logic                                  m1_err,
    output logic                                  s_req,
    output logic [31:0]                           s_addr,
    input  logic                                  s_gnt,
    input  logic                                  s_rvalid,
    input  logic [DW-1:0]                         s_rdata,
    input  logic                                  s_err,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding,
    output logic                                  protocol_err
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    logic                      prio_q, prio_d;
    logic                      lock_vld_q, lock_vld_d;
    logic                      lock_id_q, lock_id_d;
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]           count_q, count_d;
    logic                      perr_q, perr_d;

    logic        winner;
    logic        win_req;
    logic [31:0] win_addr;
    logic        full;
    logic        push;
    logic        pop;
    logic        head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    // Winner: a locked request keeps the port; otherwise round-robin on contention.
    always_comb begin
        winner = 1'b0;
        if (lock_vld_q) begin
            winner = lock_id_q;
        end else if (m0_req && m1_req) begin
            winner = prio_q;
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    assign win_req  = winner ? m1_req  : m0_req;
    assign win_addr = winner ? m1_addr : m0_addr;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign full   = (count_q == CntMax);
    assign s_req  = win_req & ~full;
    assign s_addr = win_req ? win_addr : 32'h0;

    assign m0_gnt = s_gnt & s_req & ~winner;
    assign m1_gnt = s_gnt & s_req &  winner;

    assign push = s_req & s_gnt;
    assign pop  = s_rvalid & (count_q != '0);
    assign head = fifo_q[rd_ptr_q];

    assign m0_rvalid = pop & ~head;
    assign m1_rvalid = pop &  head;
    assign m0_rdata  = m0_rvalid ? s_rdata : '0;
    assign m1_rdata  = m1_rvalid ? s_rdata : '0;
    assign m0_err    = m0_rvalid & s_err;
    assign m1_err    = m1_rvalid & s_err;

    assign outstanding  = count_q;
    assign protocol_err = perr_q;

    always_comb begin
        prio_d     = prio_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        perr_d     = perr_q;

        // Lock is only touched while s_req is high, so it survives cycles where full
        // suppresses the request.
        if (push) begin
            lock_vld_d = 1'b0;
        end else if (s_req) begin
            lock_vld_d = 1'b1;
            lock_id_d  = winner;
        end

        if (push) begin
            fifo_d[wr_ptr_q] = winner;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
            prio_d           = ~winner;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (s_rvalid && (count_q == '0)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            fifo_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            perr_q     <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            perr_q     <= perr_d;
        end
    end

endmodule

// File: tb/tb_instr_obi_arbiter.sv
// Directed bench for instr_obi_arbiter: alternation, hold lock, full back-pressure,
// response routing, unexpected responses and asynchronous reset.
module tb_instr_obi_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_gnt, m1_gnt;
    logic        m0_rvalid, m1_rvalid;
    logic [63:0] m0_rdata, m1_rdata;
    logic        m0_err, m1_err;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_gnt;
    logic        s_rvalid;
    logic [63:0] s_rdata;
    logic        s_err;
    logic [2:0]  outstanding;
    logic        protocol_err;

    int passed = 0;
    int total  = 0;

    instr_obi_arbiter #(
        .MaxOutstanding(4),
        .DW            (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_req      (m0_req),
        .m0_addr     (m0_addr),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m0_err      (m0_err),
        .m1_req      (m1_req),
        .m1_addr     (m1_addr),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .m1_err      (m1_err),
        .s_req       (s_req),
        .s_addr      (s_addr),
        .s_gnt       (s_gnt),
        .s_rvalid    (s_rvalid),
        .s_rdata     (s_rdata),
        .s_err       (s_err),
        .outstanding (outstanding),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Move to just after the next rising edge; inputs are applied here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        m0_req   = 1'b0;
        m1_req   = 1'b0;
        m0_addr  = 32'h0;
        m1_addr  = 32'h0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = 64'h0;
        s_err    = 1'b0;
        #2;
        check("rst_s_req", s_req, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_gnt", {m0_gnt, m1_gnt}, 0);
        check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_protocol_err", protocol_err, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // ---- Alternation with 1-cycle responses ----
        next_cycle();
        m0_req = 1'b1; m0_addr = 32'h8000_0000;
        m1_req = 1'b1; m1_addr = 32'h9000_0000;
        s_gnt  = 1'b1;
        #1;
        check("alt0_m0_gnt", m0_gnt, 1);
        check("alt0_m1_gnt", m1_gnt, 0);
        check("alt0_addr", s_addr, 32'h8000_0000);

        next_cycle();
        s_rvalid = 1'b1; s_rdata = 64'hD0D0_0000_0000_0000;
        #1;
        check("alt1_m1_gnt", m1_gnt, 1);
        check("alt1_m0_gnt", m0_gnt, 0);
        check("alt1_addr", s_addr, 32'h9000_0000);
        check("alt1_m0_rvalid", m0_rvalid, 1);
        check("alt1_m1_rvalid", m1_rvalid, 0);
        check("alt1_m0_rdata", m0_rdata, 64'hD0D0_0000_0000_0000);
        check("alt1_outstanding", outstanding, 1);

        next_cycle();
        s_rdata = 64'hD1D1_1111_0000_0001; s_err = 1'b1;
        #1;
        check("alt2_m0_gnt", m0_gnt, 1);
        check("alt2_m1_rvalid", m1_rvalid, 1);
        check("alt2_m1_rdata", m1_rdata, 64'hD1D1_1111_0000_0001);
        check("alt2_m1_err", m1_err, 1);
        check("alt2_m0_rdata_zero", m0_rdata, 0);
        check("alt2_m0_err_zero", m0_err, 0);

        next_cycle();
        s_rdata = 64'h0000_0000_0000_00D2; s_err = 1'b0;
        #1;
        check("alt3_m1_gnt", m1_gnt, 1);
        check("alt3_m0_rvalid", m0_rvalid, 1);
        check("alt3_m0_rdata", m0_rdata, 64'hD2);

        // Only m0 requests: gets a grant, leaving prio pointing at m1.
        next_cycle();
        m1_req = 1'b0;
        s_rdata = 64'h0000_0000_0000_00D3;
        #1;
        check("alt4_m0_gnt", m0_gnt, 1);
        check("alt4_m1_rvalid", m1_rvalid, 1);
        check("alt4_m1_rdata", m1_rdata, 64'hD3);

        next_cycle();
        m0_req = 1'b0; s_gnt = 1'b0;
        s_rdata = 64'h0000_0000_0000_00D4;
        #1;
        check("alt5_s_req", s_req, 0);
        check("alt5_s_addr_idle", s_addr, 0);
        check("alt5_m0_rvalid", m0_rvalid, 1);
        check("alt5_m0_rdata", m0_rdata, 64'hD4);

        // ---- Hold lock: m0 stalled by s_gnt low while m1 (favoured) joins ----
        next_cycle();
        s_rvalid = 1'b0; s_rdata = 64'h0;
        check("lock_pre_outstanding", outstanding, 0);
        m0_req = 1'b1; m0_addr = 32'h8000_0010;
        #1;
        check("lock0_s_req", s_req, 1);
        check("lock0_s_addr", s_addr, 32'h8000_0010);
        check("lock0_m0_gnt", m0_gnt, 0);

        next_cycle();
        m1_req = 1'b1; m1_addr = 32'h9000_0020;
        #1;
        check("lock1_s_addr", s_addr, 32'h8000_0010);
        check("lock1_m1_gnt", m1_gnt, 0);

        next_cycle();
        #1;
        check("lock2_s_addr", s_addr, 32'h8000_0010);

        next_cycle();
        s_gnt = 1'b1;
        #1;
        check("lock3_m0_gnt", m0_gnt, 1);
        check("lock3_m1_gnt", m1_gnt, 0);
        check("lock3_s_addr", s_addr, 32'h8000_0010);

        next_cycle();
        m0_req = 1'b0;
        #1;
        check("lock4_m1_gnt", m1_gnt, 1);
        check("lock4_s_addr", s_addr, 32'h9000_0020);

        next_cycle();
        m1_req = 1'b0; s_gnt = 1'b0;
        s_rvalid = 1'b1; s_rdata = 64'h55;
        #1;
        check("lock5_outstanding", outstanding, 2);
        check("lock5_m0_rvalid", m0_rvalid, 1);

        next_cycle();
        s_rdata = 64'h66;
        #1;
        check("lock6_m1_rvalid", m1_rvalid, 1);
        check("lock6_m1_rdata", m1_rdata, 64'h66);

        // ---- Fill to MaxOutstanding with no responses ----
        next_cycle();
        s_rvalid = 1'b0; s_rdata = 64'h0;
        m0_req = 1'b1; m0_addr = 32'h8000_0100; s_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fill%0d_m0_gnt", i), m0_gnt, 1);
            next_cycle();
        end
        #1;
        check("full_outstanding", outstanding, 4);
        check("full_s_req", s_req, 0);
        check("full_m0_gnt", m0_gnt, 0);

        // Pop while full: request stays suppressed this cycle.
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 64'h77;
        #1;
        check("fullpop_s_req", s_req, 0);
        check("fullpop_m0_rvalid", m0_rvalid, 1);

        next_cycle();
        s_rvalid = 1'b0;
        #1;
        check("refill_outstanding", outstanding, 3);
        check("refill_s_req", s_req, 1);
        check("refill_m0_gnt", m0_gnt, 1);

        // ---- Full with a waiting m1 request and same-cycle pop ----
        next_cycle();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h9000_0040;
        s_rvalid = 1'b1; s_rdata = 64'h88;
        #1;
        check("fp_outstanding", outstanding, 4);
        check("fp_s_req", s_req, 0);
        check("fp_m1_gnt", m1_gnt, 0);
        check("fp_m0_rvalid", m0_rvalid, 1);

        next_cycle();
        s_rvalid = 1'b0;
        #1;
        check("fp_next_outstanding", outstanding, 3);
        check("fp_next_m1_gnt", m1_gnt, 1);
        check("fp_next_s_addr", s_addr, 32'h9000_0040);

        // Drain: FIFO holds m0, m0, m0, m1.
        next_cycle();
        m1_req = 1'b0; s_gnt = 1'b0;
        s_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rdata = 64'h100 + 64'(i);
            #1;
            check($sformatf("drain%0d_m0_rvalid", i), m0_rvalid, (i < 3) ? 1 : 0);
            check($sformatf("drain%0d_m1_rvalid", i), m1_rvalid, (i == 3) ? 1 : 0);
            next_cycle();
        end

        // ---- Unexpected response ----
        #1;
        check("unexp_outstanding", outstanding, 0);
        check("unexp_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check("unexp_perr_before", protocol_err, 0);
        next_cycle();
        s_rvalid = 1'b0;
        #1;
        check("unexp_perr_set", protocol_err, 1);
        next_cycle();
        check("unexp_perr_sticky", protocol_err, 1);

        // One outstanding grant, then asynchronous reset mid-cycle.
        m0_req = 1'b1; m0_addr = 32'h8000_0200; s_gnt = 1'b1;
        next_cycle();
        m0_req = 1'b0; s_gnt = 1'b0;
        #1;
        check("prerst_outstanding", outstanding, 1);
        rst_n = 1'b0;
        #1;
        check("arst_outstanding", outstanding, 0);
        check("arst_perr", protocol_err, 0);
        next_cycle();
        rst_n = 1'b1;

        // Late response after reset is unexpected.
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 64'h99;
        #1;
        check("late_rvalid", {m0_rvalid, m1_rvalid}, 0);
        next_cycle();
        s_rvalid = 1'b0;
        #1;
        check("late_perr", protocol_err, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_obi_arbiter.md
# instr_obi_arbiter

Two-requester OBI arbiter that shares the single instruction-memory OBI port (req/gnt/rvalid, 64-bit read data) between a core fetch port (m0) and a second read-only requester (m1, e.g. debug/trace fetch). It sits between the requesters and the instruction memory model. It applies round-robin arbitration with an OBI-compliant hold lock, and tracks up to MaxOutstanding granted transactions in an in-order ID FIFO so that each response is routed back to the requester that issued it.

## Interface
- MaxOutstanding, 4, maximum granted-but-unanswered transactions (1..8)
- DW, 64, read-data width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  requester read request
- m0_addr / m1_addr  in  32  requester byte address
- m0_gnt / m1_gnt  out  1  requester grant
- m0_rvalid / m1_rvalid  out  1  requester response valid
- m0_rdata / m1_rdata  out  DW  requester response data
- m0_err / m1_err  out  1  requester response error
- s_req  out  1  shared-port request
- s_addr  out  32  shared-port address
- s_gnt  in  1  shared-port grant
- s_rvalid  in  1  shared-port response valid
- s_rdata  in  DW  shared-port response data
- s_err  in  1  shared-port response error
- outstanding  out  $clog2(MaxOutstanding+1)  current ID FIFO occupancy
- protocol_err  out  1  sticky; set on a response that arrives with no outstanding transaction

## Operation
- Registered state: prio (favoured requester, reset 0); lock_vld and lock_id (reset 0); ID FIFO of 1-bit entries with rd/wr pointers wrapping modulo MaxOutstanding; count (reset 0); protocol_err (reset 0).
- full = (count == MaxOutstanding). The check uses the registered count only. No push occurs while full, even if a pop happens in the same cycle.
- Winner selection:
  - If lock_vld, winner = lock_id.
  - Otherwise, if both requesters request, winner = prio.
  - Otherwise, winner = the single requester.
- s_req = winner's req & ~full. s_addr = winner's addr, or 0 when no request. m*_gnt = s_gnt & s_req & (winner == *). The loser's gnt is 0.
- Lock (OBI stability): if s_req & ~s_gnt, then lock_vld <= 1 and lock_id <= winner. On s_req & s_gnt, lock_vld <= 0. A lock persists across cycles where full forces s_req low.
- On an accepted handshake (s_req & s_gnt): push winner to the FIFO and set prio <= ~winner.
- Responses are in order. On s_rvalid with count > 0: pop the head ID h, assert mh_rvalid, and drive mh_rdata = s_rdata and mh_err = s_err. The other requester's rvalid is 0; its rdata and err are 0.
- On s_rvalid with count == 0: drop the response (no rvalid to either requester) and set protocol_err = 1 until reset.
- Same-cycle push and pop: count is unchanged and both pointers advance.
- Reset mid-operation: FIFO, lock, prio and count clear immediately. Responses arriving after reset release are treated as unexpected.

## Timing
- Zero-cycle combinational paths: m*_req/addr → s_req/s_addr; s_gnt → m*_gnt; s_rvalid/rdata/err → m*_rvalid/rdata/err.
- State updates (prio, lock, FIFO, count) take effect on the clk edge after the handshake.
- Response latency added by the arbiter: 0 cycles.
- Reset values: all outputs 0 while all inputs are low. outstanding = 0, protocol_err = 0.
- Back-to-back: one grant per cycle is possible. With both requesters always requesting and s_gnt = 1, grants alternate m0, m1, m0, …

## Test plan
- Both request every cycle, s_gnt = 1, response 1 cycle later. Required: grants alternate m0, m1, m0, m1 starting with m0 after reset, and each rvalid is routed to the matching requester (m0 addr 0x8000_0000 returns m0 data).
- m0 requests 0x8000_0010 with s_gnt held low for 3 cycles while m1 requests from cycle 1. Required: s_addr stays 0x8000_0010 and winner stays m0 until s_gnt. m1 is granted on the next handshake.
- MaxOutstanding = 4, s_gnt = 1, no responses. Required: exactly 4 grants, outstanding = 4, then s_req = 0. When one s_rvalid arrives, s_req re-asserts on the next cycle.
- Full with lock pending, plus a same-cycle pop. Required: no push that cycle. The locked request is granted the following cycle with the same address.
- s_rvalid pulsed with outstanding = 0. Required: no m*_rvalid, and protocol_err = 1 and sticky. Assert rst_n low mid-stream: outstanding and protocol_err return to 0 asynchronously.
